jam_perm_engine: RTL
====================

// Module: jam_perm_engine
// PURPOSE
//  Parametrised exhaustive job-assignment engine. Enumerates all N! worker->job
//  permutations in lexicographic order, sums each one's cost from an external cost
//  table, and reports the minimum cost, how many permutations reach it, and the first
//  (lexicographically smallest) optimal permutation. Sits beside the cost table ROM;
//  a start/busy handshake replaces free-running operation.
// PARAMETERS
//  N    8   workers = jobs, legal range 2..8
//  CW   7   Cost input width
//  MCW  16  MatchCount width; must hold N! (8! = 40320)
//  (localparams) IW = clog2(N) index width; SW = CW + clog2(N) sum width (N=8,CW=7 -> 10)
// PORTS
//  CLK         in   1      clock, rising edge
//  RST_N       in   1      asynchronous active-low reset
//  START       in   1      one-cycle request; sampled only in IDLE
//  BUSY        out  1      high from the cycle after START is accepted until DONE exits
//  W           out  IW     worker (row) index into the cost table
//  J           out  IW     job (column) index into the cost table
//  Cost        in   CW     Cost(W,J); combinational from W/J, sampled on the same edge
//  MinCost     out  SW     minimum total cost of the last completed run
//  MatchCount  out  MCW    number of permutations whose cost equals MinCost
//  BestPerm    out  N*IW   job of worker k at bits [k*IW +: IW]
//  Valid       out  1      one-cycle pulse: results are updated
// BEHAVIOUR
//  Reset (async, RST_N=0): state=IDLE; perm = identity (perm[k]=k); W=J=0; BUSY=0;
//   Valid=0; MinCost=0; MatchCount=0; BestPerm=identity; all working registers cleared.
//   Asserting reset mid-run aborts the run: no Valid, outputs return to reset values.
//  FSM: IDLE -> ACCUM -> EVAL -> {NEXT -> ACCUM | DONE} ; DONE -> IDLE.
//  IDLE: W=J=0. START=1 -> ACCUM; perm=identity, k=0, sum=0, first=1. START ignored
//   in every other state (no queueing).
//  ACCUM (N cycles, k=0..N-1): W=k, J=perm[k]; sum += Cost (zero-extended to SW;
//   no overflow possible). After k=N-1 -> EVAL.
//  EVAL (1 cycle): first=1 or sum<run_min -> run_min=sum, run_cnt=1,
//   run_best=perm, first=0. sum==run_min -> run_cnt += 1 (saturates at 2^MCW-1).
//   sum>run_min -> no change. Ties keep the earlier permutation in run_best.
//   perm is last (strictly descending) -> DONE, else -> NEXT.
//  NEXT (1 cycle): perm <= lexicographic successor. Pivot a = largest i with
//   perm[i]<perm[i+1]; swap perm[a] with the smallest perm[j]>perm[a], j>a; reverse
//   perm[a+1..N-1]. Single-cycle combinational. sum and k are cleared.
//  DONE (1 cycle): MinCost<=run_min, MatchCount<=run_cnt, BestPerm<=run_best,
//   Valid=1 (registered, high for exactly this cycle); -> IDLE.
//   Outputs hold until the next DONE.
//  Outside ACCUM, W=J=0.
//  Timing: N+2 cycles per permutation; the last permutation skips NEXT.
//   Valid is high N!*(N+2)-1 cycles after the edge that accepts START
//   (N=3: 29; N=8: 403199). BUSY falls together with Valid.
// TESTING
//  1 N=8, Cost=0 for all entries -> MinCost=0, MatchCount=40320,
//    BestPerm=identity, Valid 403199 cycles after START.
//  2 N=8, Cost=(W==J)?0:100 -> MinCost=0, MatchCount=1, BestPerm=0,1,..,7.
//  3 N=3, rows {5,9,2},{7,3,6},{4,8,1} -> MinCost=9 (perm 0,1,2 and 2,1,0),
//    MatchCount=2, BestPerm=0,1,2, Valid at cycle 29.
//  4 N=8, Cost=127 for all entries -> MinCost=1016 (no 10-bit overflow),
//    MatchCount=40320.
//  5 START pulsed again mid-run -> ignored, single Valid, results as in run alone;
//    a second START after DONE gives identical results.
//  6 RST_N low at cycle 1000 of a run -> outputs at reset values, no Valid;
//    a fresh START then completes normally.

Source files
------------

// File: rtl/jam_perm_engine.sv
// Exhaustive job-assignment engine: walks all N! permutations in lexicographic order,
// summing costs from an external table and keeping the minimum, its multiplicity and first hit.
module jam_perm_engine #(
   parameter int unsigned N   = 8,
   parameter int unsigned CW  = 7,
   parameter int unsigned MCW = 16,
   localparam int unsigned IW = $clog2(N),
   localparam int unsigned SW = CW + $clog2(N)
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_start,
   output logic            o_busy,
   output logic [IW-1:0]   o_w,
   output logic [IW-1:0]   o_j,
   input  logic [CW-1:0]   i_cost,
   output logic [SW-1:0]   o_min_cost,
   output logic [MCW-1:0]  o_match_count,
   output logic [N*IW-1:0] o_best_perm,
   output logic            o_valid
);

   localparam int NI = N;
   localparam logic [IW-1:0] LastK = IW'(N - 1);

   typedef logic [N-1:0][IW-1:0] perm_t;
   typedef enum logic [2:0] {StIdle, StAccum, StEval, StNext, StDone} state_t;

   state_t         r_state, w_state_next;
   perm_t          r_perm, r_run_best, r_best_perm;
   perm_t          w_ident, w_swapped, w_perm_next, w_best_d;
   logic [IW-1:0]  r_k;
   logic [SW-1:0]  r_sum, r_run_min, r_min_cost, w_min_d;
   logic [MCW-1:0] r_run_cnt, r_match_count, w_cnt_d;
   logic           r_first, r_valid, w_is_last;
   logic [IW-1:0]  w_w, w_j, w_pivot_val;
   int             w_pivot, w_succ;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= StIdle;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_w          = '0;
      w_j          = '0;
      unique case (r_state)
         StIdle:  if (i_start) w_state_next = StAccum;
         StAccum: begin
            w_w = r_k;
            w_j = r_perm[r_k];
            if (r_k == LastK) w_state_next = StEval;
         end
         StEval:  w_state_next = w_is_last ? StDone : StNext;
         StNext:  w_state_next = StAccum;
         StDone:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_comb begin
      for (int i = 0; i < NI; i++) w_ident[i] = IW'(i);
   end

   // Lexicographic successor, built from index comparisons so no variable selects are needed.
   always_comb begin
      w_is_last = 1'b1;
      w_pivot   = 0;
      for (int i = 0; i < NI - 1; i++) begin
         if (r_perm[i] < r_perm[i+1]) begin
            w_pivot   = i;
            w_is_last = 1'b0;
         end
      end
      w_pivot_val = '0;
      for (int i = 0; i < NI; i++) if (i == w_pivot) w_pivot_val = r_perm[i];
      // Suffix is descending, so the rightmost larger element is the smallest larger one.
      w_succ = 0;
      for (int i = 0; i < NI; i++)
         if (i > w_pivot && r_perm[i] > w_pivot_val) w_succ = i;
      w_swapped = r_perm;
      for (int i = 0; i < NI; i++) begin
         if (i == w_pivot) begin
            for (int m = 0; m < NI; m++) if (m == w_succ) w_swapped[i] = r_perm[m];
         end
         if (i == w_succ) w_swapped[i] = w_pivot_val;
      end
      w_perm_next = w_swapped;
      for (int i = 0; i < NI; i++)
         for (int m = 0; m < NI; m++)
            if (i > w_pivot && m == NI + w_pivot - i) w_perm_next[i] = w_swapped[m];
   end

   always_comb begin
      w_min_d  = r_run_min;
      w_cnt_d  = r_run_cnt;
      w_best_d = r_run_best;
      if (r_first || r_sum < r_run_min) begin
         w_min_d  = r_sum;
         w_cnt_d  = MCW'(1);
         w_best_d = r_perm;
      end else if (r_sum == r_run_min && r_run_cnt != '1) begin
         w_cnt_d = r_run_cnt + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NI; i++) begin
            r_perm[i]      <= IW'(i);
            r_run_best[i]  <= IW'(i);
            r_best_perm[i] <= IW'(i);
         end
         r_k           <= '0;
         r_sum         <= '0;
         r_run_min     <= '0;
         r_run_cnt     <= '0;
         r_first       <= 1'b0;
         r_min_cost    <= '0;
         r_match_count <= '0;
         r_valid       <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            StIdle: begin
               if (i_start) begin
                  r_perm  <= w_ident;
                  r_k     <= '0;
                  r_sum   <= '0;
                  r_first <= 1'b1;
               end
            end
            StAccum: begin
               r_sum <= r_sum + SW'(i_cost);
               r_k   <= (r_k == LastK) ? '0 : r_k + 1'b1;
            end
            StEval: begin
               r_run_min  <= w_min_d;
               r_run_cnt  <= w_cnt_d;
               r_run_best <= w_best_d;
               r_first    <= 1'b0;
               // Results are published on the edge entering DONE so Valid sees fresh values.
               if (w_is_last) begin
                  r_min_cost    <= w_min_d;
                  r_match_count <= w_cnt_d;
                  r_best_perm   <= w_best_d;
                  r_valid       <= 1'b1;
               end
            end
            StNext: begin
               r_perm <= w_perm_next;
               r_sum  <= '0;
               r_k    <= '0;
            end
            default: ;
         endcase
      end
   end

   assign o_busy        = (r_state != StIdle);
   assign o_w           = w_w;
   assign o_j           = w_j;
   assign o_min_cost    = r_min_cost;
   assign o_match_count = r_match_count;
   assign o_best_perm   = r_best_perm;
   assign o_valid       = r_valid;

endmodule
